snn_timestep_sequencer: RTL and testbench

//  Frame-level scheduler above the first-layer controller FSM. On each accepted preprocessed spectrum
//  it runs NUM_STEPS SNN time steps: one start pulse per step, with voltage init requested on step 0

---
 rtl/snn_timestep_sequencer.sv | 161 ++++++++++++++++
 tb/tb_snn_timestep_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_timestep_sequencer.sv
// rtl/snn_timestep_sequencer.sv - frame scheduler: runs NUM_STEPS SNN time steps, counts output
// spikes per class, resolves the winner by sequential argmax and offers it on a valid/ready handshake.
module snn_timestep_sequencer #(
  parameter int NUM_STEPS    = 16,
  parameter int NUM_CLASSES  = 18,
  parameter int CNT_W        = 8,
  parameter int STEP_TIMEOUT = 4096,
  localparam int SW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1,
  localparam int CW = $clog2(NUM_CLASSES),
  localparam int TW = $clog2(STEP_TIMEOUT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_valid,
  output logic             frame_ready,
  output logic             layer_start,
  output logic             layer_init,
  input  logic             step_done,
  input  logic             spike_valid,
  input  logic [CW-1:0]    spike_class,
  output logic [SW-1:0]    step_idx,
  output logic             busy,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [CW-1:0]    result_class,
  output logic [CNT_W-1:0] result_count,
  output logic             timeout_err
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_RUN, S_ARGMAX, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    step_q, step_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [CW-1:0]    scan_q, scan_d;
  logic [CW-1:0]    res_cls_q, res_cls_d;
  logic [CNT_W-1:0] res_cnt_q, res_cnt_d;
  logic             tmo_q, tmo_d;
  logic             start_q, start_d;
  logic             init_q, init_d;
  logic             clr_cnt;
  logic [CNT_W-1:0] scan_cnt;
  logic [CNT_W-1:0] cnt_q [NUM_CLASSES];

  always_comb begin
    scan_cnt = '0;
    for (int c = 0; c < NUM_CLASSES; c++) begin
      if (scan_q == CW'(c)) scan_cnt = cnt_q[c];
    end
  end

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    timer_d   = timer_q;
    scan_d    = scan_q;
    res_cls_d = res_cls_q;
    res_cnt_d = res_cnt_q;
    tmo_d     = tmo_q;
    clr_cnt   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (frame_valid) begin
          clr_cnt = 1'b1;
          step_d  = '0;
          tmo_d   = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        timer_d = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        timer_d = timer_q + 1'b1;
        // step_done takes priority over an expiring timer in the same cycle
        if (step_done) begin
          if (step_q == SW'(NUM_STEPS - 1)) begin
            scan_d    = '0;
            res_cls_d = '0;
            res_cnt_d = '0;
            state_d   = S_ARGMAX;
          end else begin
            step_d  = step_q + 1'b1;
            state_d = S_START;
          end
        end else if (timer_q == TW'(STEP_TIMEOUT - 1)) begin
          tmo_d     = 1'b1;
          res_cls_d = '0;
          res_cnt_d = '0;
          state_d   = S_DONE;
        end
      end
      S_ARGMAX: begin
        if (scan_cnt > res_cnt_q) begin
          res_cls_d = scan_q;
          res_cnt_d = scan_cnt;
        end
        scan_d = scan_q + 1'b1;
        if (scan_q == CW'(NUM_CLASSES - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (result_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    start_d = (state_d == S_START);
    init_d  = ((state_d == S_START) || (state_d == S_RUN)) && (step_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      step_q    <= '0;
      timer_q   <= '0;
      scan_q    <= '0;
      res_cls_q <= '0;
      res_cnt_q <= '0;
      tmo_q     <= 1'b0;
      start_q   <= 1'b0;
      init_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      timer_q   <= timer_d;
      scan_q    <= scan_d;
      res_cls_q <= res_cls_d;
      res_cnt_q <= res_cnt_d;
      tmo_q     <= tmo_d;
      start_q   <= start_d;
      init_q    <= init_d;
    end
  end

  // out-of-range class indices never match any counter, so they are dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CLASSES; c++) cnt_q[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CLASSES; c++) begin
        if (clr_cnt) begin
          cnt_q[c] <= '0;
        end else if ((state_q == S_RUN) && spike_valid && (spike_class == CW'(c))
                     && (cnt_q[c] != '1)) begin
          cnt_q[c] <= cnt_q[c] + 1'b1;
        end
      end
    end
  end

  assign frame_ready  = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign result_valid = (state_q == S_DONE);
  assign layer_start  = start_q;
  assign layer_init   = init_q;
  assign step_idx     = step_q;
  assign result_class = res_cls_q;
  assign result_count = res_cnt_q;
  assign timeout_err  = tmo_q;

endmodule

// File: tb/tb_snn_timestep_sequencer.sv
// tb/tb_snn_timestep_sequencer.sv - directed bench for snn_timestep_sequencer (4 steps, 18 classes,
// timeout 64) with a second CNT_W=4 instance sharing the stimulus for the saturation case.
module tb_snn_timestep_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_valid = 1'b0;
  logic       step_done = 1'b0;
  logic       spike_valid = 1'b0;
  logic [4:0] spike_class = '0;
  logic       result_ready = 1'b0;

  logic       frame_ready, layer_start, layer_init, busy, result_valid, timeout_err;
  logic [1:0] step_idx;
  logic [4:0] result_class;
  logic [7:0] result_count;

  logic       frame_ready4, layer_start4, layer_init4, busy4, result_valid4, timeout_err4;
  logic [1:0] step_idx4;
  logic [4:0] result_class4;
  logic [3:0] result_count4;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int t0 = 0;
  int ls_cnt = 0;
  int init_hi = 0;
  int init_bad = 0;
  int plan [4][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (layer_start) ls_cnt++;
      if (layer_init) begin
        init_hi++;
        if (step_idx != 2'd0) init_bad++;
      end
    end
  end

  snn_timestep_sequencer #(.NUM_STEPS(4), .NUM_CLASSES(18), .CNT_W(8), .STEP_TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .layer_start(layer_start), .layer_init(layer_init), .step_done(step_done),
    .spike_valid(spike_valid), .spike_class(spike_class), .step_idx(step_idx), .busy(busy),
    .result_valid(result_valid), .result_ready(result_ready), .result_class(result_class),
    .result_count(result_count), .timeout_err(timeout_err));

  snn_timestep_sequencer #(.NUM_STEPS(4), .NUM_CLASSES(18), .CNT_W(4), .STEP_TIMEOUT(64)) dut4 (
    .clk(clk), .rst(rst), .frame_valid(frame_valid), .frame_ready(frame_ready4),
    .layer_start(layer_start4), .layer_init(layer_init4), .step_done(step_done),
    .spike_valid(spike_valid), .spike_class(spike_class), .step_idx(step_idx4), .busy(busy4),
    .result_valid(result_valid4), .result_ready(result_ready), .result_class(result_class4),
    .result_count(result_count4), .timeout_err(timeout_err4));

  task automatic clear_plan();
    for (int s = 0; s < 4; s++) plan[s].delete();
  endtask

  task automatic start_frame();
    @(negedge clk);
    frame_valid = 1'b1;
    t0 = cyc;
    @(negedge clk);
    frame_valid = 1'b0;
  endtask

  task automatic drive_step(input int s, input int len);
    int n = 0;
    while (!layer_start && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!layer_start) begin
      total_cnt++;
      $display("FAIL step_wait: no layer_start for step %0d within %0d cycles", s, n);
    end
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      spike_valid = 1'b0;
      step_done = 1'b0;
      if (k - 1 < plan[s].size()) begin
        spike_valid = 1'b1;
        spike_class = 5'(plan[s][k-1]);
      end
      if (k == len) step_done = 1'b1;
    end
    @(negedge clk);
    spike_valid = 1'b0;
    step_done = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    int n = 0;
    while (!result_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    lat = cyc - t0;
    if (!result_valid) begin
      total_cnt++;
      $display("FAIL result_wait: result_valid never rose within %0d cycles", n);
    end
  endtask

  task automatic run_frame(input int len, output int lat);
    start_frame();
    for (int s = 0; s < 4; s++) drive_step(s, len);
    wait_result(lat);
  endtask

  task automatic handshake();
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total_cnt++;
    if ({frame_ready, busy, layer_start, layer_init, result_valid, timeout_err} !== 6'b100000)
      $display("FAIL reset_flags: got %b need 100000",
               {frame_ready, busy, layer_start, layer_init, result_valid, timeout_err});
    else pass_cnt++;
    total_cnt++;
    if ({step_idx, result_class, result_count} !== 15'd0)
      $display("FAIL reset_values: step %0d class %0d count %0d need 0", step_idx, result_class, result_count);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    step_done = 1'b1;
    @(negedge clk);
    step_done = 1'b0;
    total_cnt++;
    if (busy !== 1'b0 || frame_ready !== 1'b1)
      $display("FAIL idle_step_done: busy %b frame_ready %b need 0/1", busy, frame_ready);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    int lat;
    clear_plan();
    plan[0] = '{5, 5};
    plan[1] = '{2};
    plan[2] = '{5};
    ls_cnt = 0;
    init_hi = 0;
    init_bad = 0;
    run_frame(10, lat);
    total_cnt++;
    if (ls_cnt !== 4) $display("FAIL basic_starts: got %0d pulses need 4", ls_cnt); else pass_cnt++;
    total_cnt++;
    if (init_hi !== 11 || init_bad !== 0)
      $display("FAIL basic_init: high %0d cycles (bad %0d) need 11 (0)", init_hi, init_bad);
    else pass_cnt++;
    total_cnt++;
    if (lat !== 63) $display("FAIL basic_latency: got %0d need 63", lat); else pass_cnt++;
    total_cnt++;
    if (result_class !== 5'd5 || result_count !== 8'd3 || timeout_err !== 1'b0)
      $display("FAIL basic_result: class %0d count %0d tmo %b need 5 3 0", result_class, result_count, timeout_err);
    else pass_cnt++;
    handshake();
  endtask

  task automatic test_tie();
    int lat;
    clear_plan();
    plan[1] = '{7, 3};
    plan[3] = '{3, 7};
    run_frame(6, lat);
    total_cnt++;
    if (result_class !== 5'd3 || result_count !== 8'd2)
      $display("FAIL tie_result: class %0d count %0d need 3 2", result_class, result_count);
    else pass_cnt++;
    handshake();
  endtask

  task automatic test_saturation();
    int lat;
    clear_plan();
    plan[0] = '{1, 1, 1, 1, 1, 18, 18, 1};
    plan[1] = '{1, 1, 1, 1, 1, 18};
    plan[2] = '{1, 1, 1, 1, 1};
    plan[3] = '{1, 1, 1, 1, 18};
    run_frame(10, lat);
    total_cnt++;
    if (result_class4 !== 5'd1 || result_count4 !== 4'd15)
      $display("FAIL sat_result4: class %0d count %0d need 1 15", result_class4, result_count4);
    else pass_cnt++;
    total_cnt++;
    if (result_class !== 5'd1 || result_count !== 8'd20)
      $display("FAIL sat_result8: class %0d count %0d need 1 20", result_class, result_count);
    else pass_cnt++;
    handshake();
  endtask

  task automatic test_timeout();
    int n = 0;
    int lat;
    clear_plan();
    start_frame();
    while (!result_valid && n < 200) begin
      @(negedge clk);
      n++;
      spike_valid = (n == 3);
      spike_class = 5'd4;
    end
    spike_valid = 1'b0;
    total_cnt++;
    if (n !== 65) $display("FAIL tmo_latency: result after %0d cycles need 65", n); else pass_cnt++;
    total_cnt++;
    if (timeout_err !== 1'b1 || result_class !== 5'd0 || result_count !== 8'd0)
      $display("FAIL tmo_result: tmo %b class %0d count %0d need 1 0 0", timeout_err, result_class, result_count);
    else pass_cnt++;
    handshake();
    start_frame();
    total_cnt++;
    if (timeout_err !== 1'b0) $display("FAIL tmo_clear_on_accept: got %b need 0", timeout_err); else pass_cnt++;
    for (int s = 0; s < 4; s++) drive_step(s, 4);
    wait_result(lat);
    total_cnt++;
    if (timeout_err !== 1'b0 || result_count !== 8'd0)
      $display("FAIL tmo_next_frame: tmo %b count %0d need 0 0", timeout_err, result_count);
    else pass_cnt++;
    handshake();
  endtask

  task automatic test_reset_midframe();
    int lat;
    clear_plan();
    plan[0] = '{9, 9};
    plan[1] = '{9};
    start_frame();
    drive_step(0, 5);
    drive_step(1, 5);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({frame_ready, busy, layer_start, layer_init, result_valid, timeout_err} !== 6'b100000 ||
        {step_idx, result_class, result_count} !== 15'd0)
      $display("FAIL midreset_outputs: flags %b step %0d class %0d count %0d need 100000 0 0 0",
               {frame_ready, busy, layer_start, layer_init, result_valid, timeout_err},
               step_idx, result_class, result_count);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (frame_ready !== 1'b1) $display("FAIL midreset_ready: got %b need 1", frame_ready); else pass_cnt++;
    clear_plan();
    plan[1] = '{9};
    run_frame(5, lat);
    total_cnt++;
    if (result_class !== 5'd9 || result_count !== 8'd1)
      $display("FAIL midreset_next: class %0d count %0d need 9 1", result_class, result_count);
    else pass_cnt++;
    handshake();
  endtask

  task automatic test_backpressure();
    int lat;
    int ls0;
    clear_plan();
    plan[0] = '{11};
    run_frame(3, lat);
    ls0 = ls_cnt;
    for (int i = 0; i < 5; i++) begin
      frame_valid = (i % 2 == 0);
      @(negedge clk);
      total_cnt++;
      if (result_valid !== 1'b1 || result_class !== 5'd11 || result_count !== 8'd1 || frame_ready !== 1'b0)
        $display("FAIL hold_cycle%0d: valid %b class %0d count %0d ready %b need 1 11 1 0",
                 i, result_valid, result_class, result_count, frame_ready);
      else pass_cnt++;
    end
    frame_valid = 1'b0;
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    total_cnt++;
    if (frame_ready !== 1'b1 || result_valid !== 1'b0)
      $display("FAIL hold_release: ready %b valid %b need 1 0", frame_ready, result_valid);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (ls_cnt !== ls0 || busy !== 1'b0)
      $display("FAIL hold_no_queue: starts %0d busy %b need %0d 0", ls_cnt, busy, ls0);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_saturation();
    test_timeout();
    test_reset_midframe();
    test_backpressure();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
